// File: rtl/dmac_write_engine.sv
// DMAC write engine: pops write descriptors, buffers R beats, issues AW then W per burst, retires B.
// Define DMAC_WR_RLAST_CHECK_EN to store rlast per beat and raise sticky err_o on a wlast mismatch.
module dmac_write_engine #(
    parameter int DATA_DEPTH      = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        meta_empty_i,
    input  logic [31:0] meta_awaddr_i,
    input  logic [3:0]  meta_awlen_i,
    output logic        meta_rden_o,
    input  logic [31:0] rdata_i,
    input  logic        rlast_i,
    input  logic        rvalid_i,
    output logic        rready_o,
    output logic [31:0] awaddr_o,
    output logic [3:0]  awlen_o,
    output logic [2:0]  awsize_o,
    output logic [1:0]  awburst_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wlast_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    input  logic        bvalid_i,
    output logic        bready_o,
    output logic        idle_o,
    output logic        err_o
);
    localparam int PW = $clog2(DATA_DEPTH);
`ifdef DMAC_WR_RLAST_CHECK_EN
    localparam int EW = 33;
`else
    localparam int EW = 32;
`endif
    localparam logic [PW:0] FULL_CNT  = (PW+1)'(DATA_DEPTH);
    localparam logic [3:0]  MAX_OUT_C = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W} state_t;

    state_t          state_q, state_d;
    logic [31:0]     awaddr_q, awaddr_d;
    logic [3:0]      awlen_q, awlen_d;
    logic [3:0]      bcnt_q, bcnt_d;
    logic [3:0]      ocnt_q, ocnt_d;
    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]     cnt_q, cnt_d;
    logic [EW-1:0]   mem_q [DATA_DEPTH];
    logic [EW-1:0]   fifo_din;
    logic [EW-1:0]   head;
    logic            fifo_empty, fifo_full, push, pop, aw_hs, b_hs;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FULL_CNT);
    assign rready_o   = !fifo_full;
    assign push       = rvalid_i && rready_o;
    assign pop        = wvalid_o && wready_i;
    assign head       = mem_q[rptr_q];
    // Head is masked while empty so wdata_o reads 0 out of reset rather than stale storage.
    assign wdata_o    = fifo_empty ? 32'h0 : head[31:0];

    assign awaddr_o   = awaddr_q;
    assign awlen_o    = awlen_q;
    assign awsize_o   = 3'b010;
    assign awburst_o  = 2'b01;
    assign wstrb_o    = 4'hF;
    assign bready_o   = 1'b1;
    assign aw_hs      = awvalid_o && awready_i;
    // A B response with nothing outstanding is dropped so ocnt cannot wrap.
    assign b_hs       = bvalid_i && bready_o && (ocnt_q != 4'd0);
    assign idle_o     = (state_q == S_IDLE) && meta_empty_i && fifo_empty && (ocnt_q == 4'd0);

`ifdef DMAC_WR_RLAST_CHECK_EN
    logic err_q, err_d;
    assign fifo_din = {rlast_i, rdata_i};
    assign err_d    = err_q || (pop && (head[32] != wlast_o));
    assign err_o    = err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
`else
    logic unused_rlast;
    assign unused_rlast = rlast_i;
    assign fifo_din     = rdata_i;
    assign err_o        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        bcnt_d      = bcnt_q;
        meta_rden_o = 1'b0;
        awvalid_o   = 1'b0;
        wvalid_o    = 1'b0;
        wlast_o     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!meta_empty_i && (ocnt_q < MAX_OUT_C)) begin
                    meta_rden_o = 1'b1;
                    awaddr_d    = meta_awaddr_i;
                    awlen_d     = meta_awlen_i;
                    bcnt_d      = meta_awlen_i;
                    state_d     = S_AW;
                end
            end
            S_AW: begin
                awvalid_o = 1'b1;
                if (awready_i) state_d = S_W;
            end
            S_W: begin
                wvalid_o = !fifo_empty;
                wlast_o  = (bcnt_q == 4'd0);
                if (wvalid_o && wready_i) begin
                    if (bcnt_q == 4'd0) state_d = S_IDLE;
                    else                bcnt_d  = bcnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wptr_d = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
        cnt_d  = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + (PW+1)'(1);
        else if (pop && !push) cnt_d = cnt_q - (PW+1)'(1);
        ocnt_d = ocnt_q;
        if (aw_hs && !b_hs)      ocnt_d = ocnt_q + 4'd1;
        else if (b_hs && !aw_hs) ocnt_d = ocnt_q - 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            awaddr_q <= 32'h0;
            awlen_q  <= 4'h0;
            bcnt_q   <= 4'h0;
            ocnt_q   <= 4'h0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            awaddr_q <= awaddr_d;
            awlen_q  <= awlen_d;
            bcnt_q   <= bcnt_d;
            ocnt_q   <= ocnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= fifo_din;
    end
endmodule

// File: tb/tb_dmac_write_engine.sv
// Directed bench for dmac_write_engine: meta FIFO model, R-beat driver and AXI slave,
// with AW/W expectations queued at stimulus time and compared when the engine emits them.
`timescale 1ns/1ps
module tb_dmac_write_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        meta_empty, meta_rden;
    logic [31:0] meta_awaddr;
    logic [3:0]  meta_awlen;
    logic [31:0] rdata;
    logic        rlast, rvalid, rready;
    logic [31:0] awaddr, wdata;
    logic [3:0]  awlen, wstrb;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready, idle, err;

    dmac_write_engine #(.DATA_DEPTH(16), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .meta_empty_i(meta_empty), .meta_awaddr_i(meta_awaddr), .meta_awlen_i(meta_awlen),
        .meta_rden_o(meta_rden),
        .rdata_i(rdata), .rlast_i(rlast), .rvalid_i(rvalid), .rready_o(rready),
        .awaddr_o(awaddr), .awlen_o(awlen), .awsize_o(awsize), .awburst_o(awburst),
        .awvalid_o(awvalid), .awready_i(awready),
        .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast), .wvalid_o(wvalid), .wready_i(wready),
        .bvalid_i(bvalid), .bready_o(bready), .idle_o(idle), .err_o(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Meta FIFO model, first-word-fall-through
    logic [31:0] m_addr [64];
    logic [3:0]  m_len  [64];
    int m_wr = 0;
    int m_rd = 0;
    assign meta_empty  = (m_wr == m_rd);
    assign meta_awaddr = m_addr[m_rd % 64];
    assign meta_awlen  = m_len[m_rd % 64];
    always @(posedge clk) if (rst_n && meta_rden) m_rd <= m_rd + 1;

    // Scoreboard
    logic [31:0] exp_aw_addr [$];
    logic [3:0]  exp_aw_len  [$];
    logic [31:0] exp_wd      [$];
    logic        exp_wl      [$];

    int aw_cnt = 0, wl_cnt = 0, rden_cnt = 0, rden_cyc = 0, lastw_cyc = 0;
    logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_rden = 0, p_wlast = 0;
    logic [31:0] p_awaddr = 0, p_wdata = 0;
    logic [3:0]  p_awlen = 0;
    logic [31:0] ea, ed;
    logic [3:0]  el;
    logic        elast;

    always @(negedge clk) begin
        if (rst_n) begin
            if (p_awv && !p_awr) check("aw_hold", {awvalid, awlen, awaddr}, {1'b1, p_awlen, p_awaddr});
            if (p_wv && !p_wr)   check("w_hold", {wvalid, wlast, wdata}, {1'b1, p_wlast, p_wdata});
            if (p_rden)          check("aw_after_rden", awvalid, 1'b1);
            if (meta_rden) begin
                rden_cnt++;
                rden_cyc = cyc;
                check("rden_nonempty", meta_empty, 1'b0);
            end
            if (awvalid && awready) begin
                aw_cnt++;
                if (exp_aw_addr.size() == 0) check("aw_unexpected", 1'b1, 1'b0);
                else begin
                    ea = exp_aw_addr.pop_front();
                    el = exp_aw_len.pop_front();
                    check("aw_addr", awaddr, ea);
                    check("aw_len", awlen, el);
                end
            end
            if (wvalid && wready) begin
                check("w_after_aw", aw_cnt > wl_cnt, 1'b1);
                if (exp_wd.size() == 0 || exp_wl.size() == 0) check("w_unexpected", 1'b1, 1'b0);
                else begin
                    ed    = exp_wd.pop_front();
                    elast = exp_wl.pop_front();
                    check("w_data", wdata, ed);
                    check("w_last", wlast, elast);
                end
                if (wlast) begin
                    wl_cnt++;
                    lastw_cyc = cyc;
                end
            end
        end
        p_awv = awvalid; p_awr = awready; p_awaddr = awaddr; p_awlen = awlen;
        p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wlast = wlast;
        p_rden = rst_n && meta_rden;
    end

    task automatic add_desc(input logic [31:0] addr, input logic [3:0] len);
        m_addr[m_wr % 64] = addr;
        m_len[m_wr % 64]  = len;
        m_wr++;
        exp_aw_addr.push_back(addr);
        exp_aw_len.push_back(len);
        for (int i = 0; i <= int'(len); i++) exp_wl.push_back(i == int'(len));
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        bit ok = 0;
        rvalid = 1'b1; rdata = d; rlast = l;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rready) begin ok = 1; break; end
        end
        if (ok) exp_wd.push_back(d);
        else    check("r_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        rvalid = 1'b0;
    endtask

    task automatic send_b();
        bvalid = 1'b1;
        @(posedge clk); #1;
        bvalid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_wl(input string tag, input int target);
        for (int i = 0; i < 400; i++) begin
            if (wl_cnt >= target) break;
            @(negedge clk);
        end
        check(tag, wl_cnt >= target, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (idle) break;
        end
        check(tag, idle, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int a0, r0;

    initial begin
        rst_n = 0; rvalid = 0; rdata = 0; rlast = 0;
        awready = 1; wready = 1; bvalid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rden",    meta_rden, 1'b0);
        check("rst_rready",  rready, 1'b1);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_awaddr",  awaddr, 32'h0);
        check("rst_awlen",   awlen, 4'h0);
        check("rst_wvalid",  wvalid, 1'b0);
        check("rst_wlast",   wlast, 1'b0);
        check("rst_wdata",   wdata, 32'h0);
        check("rst_idle",    idle, 1'b1);
        check("rst_err",     err, 1'b0);
        check("const_aw",    {awsize, awburst}, {3'b010, 2'b01});
        check("const_wb",    {wstrb, bready}, {4'hF, 1'b1});
        @(posedge clk); #1;
        rst_n = 1;
        step(2);

        // Single 16-beat burst, data queued ahead of the descriptor
        for (int i = 0; i < 16; i++) send_beat(32'(i), i == 15);
        add_desc(32'h0000_1000, 4'd15);
        wait_wl("single_done", 1);
        check("single_latency", lastw_cyc - rden_cyc, 17);
        check("single_wait_b", idle, 1'b0);
        send_b();
        wait_idle("single_idle");

        // Short burst, single meta pop
        r0 = rden_cnt;
        for (int i = 0; i < 4; i++) send_beat(32'hA0 + 32'(i), i == 3);
        add_desc(32'h0000_2000, 4'd3);
        wait_wl("short_done", 2);
        step(3);
        check("short_rden_once", rden_cnt - r0, 1);
        send_b();
        wait_idle("short_idle");

        // Outstanding limit
        a0 = aw_cnt;
        for (int i = 0; i < 6; i++) send_beat(32'h300 + 32'(i), 1'b1);
        for (int i = 0; i < 6; i++) add_desc(32'h3000 + 32'(16 * i), 4'd0);
        step(40);
        check("ost_four_aw", aw_cnt - a0, 4);
        check("ost_stalled_aw", awvalid, 1'b0);
        check("ost_meta_left", meta_empty, 1'b0);
        send_b();
        step(10);
        check("ost_fifth_aw", aw_cnt - a0, 5);
        send_b();
        step(10);
        check("ost_sixth_aw", aw_cnt - a0, 6);
        for (int i = 0; i < 4; i++) send_b();
        wait_idle("ost_idle");
        send_b();
        step(2);
        check("stray_b_idle", idle, 1'b1);

        // Back-pressure: AW held off 5 cycles, wready toggling
        awready = 0;
        for (int i = 0; i < 8; i++) send_beat(32'hB0 + 32'(i), i == 7);
        add_desc(32'h0000_4000, 4'd7);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (awvalid) break;
        end
        check("bp_aw_seen", awvalid, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            wready = (i % 2 == 1);
            step(1);
        end
        awready = 1;
        for (int i = 0; i < 40; i++) begin
            wready = (i % 2 == 0);
            step(1);
        end
        wready = 1;
        wait_wl("bp_done", wl_cnt >= 9 ? wl_cnt : 9);
        send_b();
        wait_idle("bp_idle");

        // Data FIFO fill while AW is stalled
        a0 = wl_cnt;
        awready = 0;
        add_desc(32'h0000_5000, 4'd15);
        add_desc(32'h0000_5100, 4'd3);
        for (int i = 0; i < 16; i++) send_beat(32'hC00 + 32'(i), i == 15);
        @(negedge clk);
        check("full_rready_low", rready, 1'b0);
        @(posedge clk); #1;
        awready = 1;
        for (int i = 16; i < 20; i++) send_beat(32'hC00 + 32'(i), i == 19);
        wait_wl("full_done", a0 + 2);
        send_b();
        send_b();
        wait_idle("full_idle");
        check("sb_w_empty", exp_wd.size(), 0);
        check("sb_aw_empty", exp_aw_addr.size(), 0);
        check("err_clean", err, 1'b0);

`ifdef DMAC_WR_RLAST_CHECK_EN
        a0 = wl_cnt;
        for (int i = 0; i < 4; i++) send_beat(32'hD0 + 32'(i), i == 2);
        add_desc(32'h0000_6000, 4'd3);
        wait_wl("err_done", a0 + 1);
        check("err_set", err, 1'b1);
        send_b();
        wait_idle("err_idle");
        check("err_sticky", err, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
